// File: rtl/square_scheduler.sv
// -----------------------------------------------------------------------------
// square_scheduler
//
// Shared squaring engine behind a round-robin scheduler. Several requesters
// offer unsigned operands; one is granted at a time, its square is built by
// an iterative shift-add datapath (one partial product per cycle) and the
// result is returned together with the requester's index.
//
// Handshake rule (both ports): a transfer happens on a rising clock edge where
// valid and ready are both high. The requester side is ready-driven: the
// block raises at most one req_ready bit, only for a requester whose
// req_valid is high, and only while idle. The result side holds res_valid,
// res_data and res_id stable until res_ready is seen high.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   req_valid  [NREQ]        requester i offers an operand
//   req_data   [NREQ*WIDTH]  operand i at bits [i*WIDTH +: WIDTH]
//   req_ready  [NREQ]        one-hot accept, combinational in IDLE
//   res_valid                result available (state DONE)
//   res_ready                consumer accepts result
//   res_data   [2*WIDTH]     square of the accepted operand
//   res_id     [IDW]         index of the requester that supplied it
//   busy                     high whenever the FSM is not idle
//   state_dbg  [2]           current FSM state encoding (IDLE=0 CALC=1 DONE=2)
// -----------------------------------------------------------------------------
module square_scheduler #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   output logic [NREQ-1:0]         req_ready,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [2*WIDTH-1:0]      res_data,
   output logic [IDW-1:0]          res_id,
   output logic                    busy,
   output logic [1:0]              state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t               state, state_nxt;
   logic [IDW-1:0]       ptr;
   logic [IDW-1:0]       id;
   logic [WIDTH-1:0]     op;
   logic [2*WIDTH-1:0]   acc;
   logic [CW-1:0]        cnt;

   logic                 grant_found;
   logic [IDW-1:0]       grant_id;
   logic [IDW-1:0]       arb_idx;
   logic [2*WIDTH-1:0]   op_ext;

   assign op_ext = {{WIDTH{1'b0}}, op};

   // Round-robin search starting at ptr. NREQ is a power of two, so the
   // IDW-bit addition wraps modulo NREQ for free.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      arb_idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         arb_idx = ptr + IDW'(k);
         if (!grant_found && req_valid[arb_idx]) begin
            grant_found = 1'b1;
            grant_id    = arb_idx;
         end
      end
   end

   // Next-state and handshake outputs. req_ready is suppressed while rst is
   // high because the asynchronous reset already forces IDLE, which would
   // otherwise let a grant leak out during reset.
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      case (state)
         IDLE: begin
            if (grant_found && !rst) begin
               req_ready[grant_id] = 1'b1;
               state_nxt           = CALC;
            end
         end
         CALC: begin
            if (cnt == CW'(WIDTH - 1)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Datapath: capture on the grant edge, then one partial product per cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
         id  <= '0;
         op  <= '0;
         acc <= '0;
         cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  op  <= req_data[grant_id*WIDTH +: WIDTH];
                  id  <= grant_id;
                  acc <= '0;
                  cnt <= '0;
                  ptr <= grant_id + 1'b1;
               end
            end
            CALC: begin
               if (op[cnt]) begin
                  acc <= acc + (op_ext << cnt);
               end
               cnt <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign res_valid = (state == DONE);
   assign res_data  = acc;
   assign res_id    = id;
   assign busy      = (state != IDLE);
   assign state_dbg = state;

endmodule

// File: tb/tb_square_scheduler.sv
// -----------------------------------------------------------------------------
// tb_square_scheduler
//
// Directed and randomized bench for square_scheduler. The reference model
// works at transaction level: a round-robin pick function over a pointer
// integer, the square computed with plain multiplication, and an expected
// result queue. A second instance (WIDTH=3, NREQ=2) covers the small
// parameter point.
// -----------------------------------------------------------------------------
module tb_square_scheduler;

   localparam int W   = 8;
   localparam int N   = 4;
   localparam int IDW = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle++;

   // ---------------- DUT 1 (WIDTH=8, NREQ=4) ----------------
   logic [N-1:0]     req_valid;
   logic [N*W-1:0]   req_data;
   logic [N-1:0]     req_ready;
   logic             res_valid;
   logic             res_ready;
   logic [2*W-1:0]   res_data;
   logic [IDW-1:0]   res_id;
   logic             busy;
   logic [1:0]       state_dbg;

   square_scheduler #(.WIDTH(W), .NREQ(N)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_id(res_id), .busy(busy), .state_dbg(state_dbg)
   );

   // ---------------- DUT 2 (WIDTH=3, NREQ=2) ----------------
   logic [1:0]  rv2;
   logic [5:0]  rd2;
   logic [1:0]  rr2;
   logic        res_v2;
   logic        res_r2;
   logic [5:0]  res_d2;
   logic [0:0]  res_id2;
   logic        busy2;
   logic [1:0]  sd2;

   square_scheduler #(.WIDTH(3), .NREQ(2)) dut2 (
      .clk(clk), .rst(rst),
      .req_valid(rv2), .req_data(rd2), .req_ready(rr2),
      .res_valid(res_v2), .res_ready(res_r2), .res_data(res_d2),
      .res_id(res_id2), .busy(busy2), .state_dbg(sd2)
   );

   // ---------------- scoreboard / model ----------------
   int checks   = 0;
   int failures = 0;
   logic [2*W-1:0] exp_q[$];
   int grant_cyc[$];
   logic [W-1:0] ops [N];
   int  m_ptr;
   bit  jitter;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] m, input int p);
      for (int k = 0; k < N; k++) begin
         if (m[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_data();
      for (int i = 0; i < N; i++) req_data[i*W +: W] = ops[i];
   endtask

   // One complete transaction from the IDLE cycle through the result
   // handshake. hold = number of DONE cycles with res_ready low.
   task automatic run_txn(input logic [N-1:0] vmask, input int hold, input bit keep,
                          input string tag, output int g);
      logic [2*W-1:0] e;
      set_data();
      req_valid = vmask;
      #1;
      g = rr_pick(vmask, m_ptr);
      chk({tag, ":busy_idle"}, 32'(busy), 32'd0);
      chk({tag, ":req_ready"}, 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
      if (g < 0) begin
         step();
         return;
      end
      exp_q.push_back((2*W)'(ops[g]) * (2*W)'(ops[g]));
      m_ptr = (g + 1) % N;
      step();
      grant_cyc.push_back(cycle);
      if (!keep) req_valid = '0;
      for (int k = 0; k < W; k++) begin
         if (jitter) begin
            for (int i = 0; i < N; i++) ops[i] = W'($urandom_range(0, 255));
            set_data();
            req_valid = N'($urandom_range(0, 15));
         end
         res_ready = 1'($urandom_range(0, 1));
         #1;
         chk({tag, ":calc_res_valid"}, 32'(res_valid), 32'd0);
         chk({tag, ":calc_busy"}, 32'(busy), 32'd1);
         chk({tag, ":calc_req_ready"}, 32'(req_ready), 32'd0);
         step();
      end
      e = exp_q.pop_front();
      for (int h = 0; h <= hold; h++) begin
         res_ready = (h == hold);
         #1;
         chk({tag, ":res_valid"}, 32'(res_valid), 32'd1);
         chk({tag, ":res_data"}, 32'(res_data), 32'(e));
         chk({tag, ":res_id"}, 32'(res_id), 32'(g));
         chk({tag, ":done_req_ready"}, 32'(req_ready), 32'd0);
         chk({tag, ":done_busy"}, 32'(busy), 32'd1);
         step();
      end
      res_ready = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int g;
      int ids[$];
      int exp_ids[5];
      int bnd[4];
      exp_ids = '{0, 1, 2, 3, 0};
      bnd     = '{0, 1, 255, 128};
      jitter  = 1'b0;
      m_ptr   = 0;

      // Reset: outputs quiet even with every requester asking.
      rst = 1'b1;
      req_valid = '1;
      for (int i = 0; i < N; i++) ops[i] = W'($urandom_range(0, 255));
      set_data();
      res_ready = 1'b0;
      rv2 = '0; rd2 = '0; res_r2 = 1'b0;
      step();
      step();
      chk("rst:req_ready", 32'(req_ready), 32'd0);
      chk("rst:res_valid", 32'(res_valid), 32'd0);
      chk("rst:res_data", 32'(res_data), 32'd0);
      chk("rst:res_id", 32'(res_id), 32'd0);
      chk("rst:busy", 32'(busy), 32'd0);
      chk("rst:state", 32'(state_dbg), 32'd0);
      req_valid = '0;
      rst = 1'b0;
      step();

      // Single operand 13 from requester 0.
      ops[0] = 8'd13;
      run_txn(4'b0001, 0, 1'b0, "t13", g);
      chk("t13:id", 32'(g), 32'd0);

      // Boundary operands on requester 2.
      for (int i = 0; i < 4; i++) begin
         ops[2] = W'(bnd[i]);
         run_txn(4'b0100, 0, 1'b0, "bnd", g);
      end

      // Back-pressure on requester 3 with requester 0 pending throughout.
      ops[3] = 8'd200;
      ops[0] = 8'd11;
      run_txn(4'b1001, 20, 1'b1, "bp", g);
      chk("bp:id", 32'(g), 32'd3);
      run_txn(4'b1001, 0, 1'b0, "bp_next", g);
      chk("bp_next:id", 32'(g), 32'd0);

      // Reset during the 4th CALC cycle of requester 1's operand 100.
      ops[1] = 8'd100;
      set_data();
      req_valid = 4'b0010;
      #1;
      chk("mid:req_ready", 32'(req_ready), 32'd2);
      step();
      req_valid = 4'b0011;
      step();
      step();
      step();
      rst = 1'b1;
      #1;
      chk("mid:rst_res_valid", 32'(res_valid), 32'd0);
      chk("mid:rst_busy", 32'(busy), 32'd0);
      chk("mid:rst_req_ready", 32'(req_ready), 32'd0);
      chk("mid:rst_res_data", 32'(res_data), 32'd0);
      step();
      step();
      rst = 1'b0;
      req_valid = '0;
      m_ptr = 0;
      for (int k = 0; k < 10; k++) begin
         #1;
         chk("mid:no_stale", 32'(res_valid), 32'd0);
         step();
      end

      // All four requesters continuously valid.
      ops[0] = 8'd3; ops[1] = 8'd5; ops[2] = 8'd7; ops[3] = 8'd9;
      grant_cyc.delete();
      for (int t = 0; t < 5; t++) begin
         run_txn(4'b1111, 0, 1'b1, "rr", g);
         ids.push_back(g);
      end
      for (int t = 0; t < 5; t++) chk("rr:order", 32'(ids[t]), 32'(exp_ids[t]));
      for (int t = 1; t < 5; t++) chk("rr:spacing", 32'(grant_cyc[t] - grant_cyc[t-1]), 32'd10);
      req_valid = '0;
      step();

      // Randomized traffic with jittering inputs and back-pressure.
      jitter = 1'b1;
      for (int t = 0; t < 40; t++) begin
         logic [N-1:0] m;
         m = N'($urandom_range(0, 15));
         for (int i = 0; i < N; i++) ops[i] = W'($urandom_range(0, 255));
         if (m == '0) begin
            set_data();
            req_valid = '0;
            #1;
            chk("rnd:idle_req_ready", 32'(req_ready), 32'd0);
            step();
         end else begin
            run_txn(m, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rnd", g);
         end
      end
      jitter = 1'b0;
      req_valid = '0;
      step();

      // Small parameter point: WIDTH=3, NREQ=2, operands 0..7.
      for (int i = 0; i < 8; i++) begin
         rv2 = 2'b11;
         rd2 = {3'(i), 3'(i)};
         #1;
         chk("sw:req_ready", 32'(rr2), 32'd1 << (i % 2));
         step();
         rv2 = '0;
         step();
         step();
         #1;
         chk("sw:early", 32'(res_v2), 32'd0);
         step();
         #1;
         chk("sw:res_valid", 32'(res_v2), 32'd1);
         chk("sw:res_data", 32'(res_d2), 32'(i * i));
         chk("sw:res_id", 32'(res_id2), 32'(i % 2));
         res_r2 = 1'b1;
         step();
         res_r2 = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
